// File: rtl/pl_symbol_scrambler.sv
`default_nettype none
// ============================================================================
// Module      : pl_symbol_scrambler
// Description : Frame-aware QPSK symbol scrambler. Header symbols pass through
//               unchanged; payload symbols are rotated by Rn*90 degrees.
// Revision    : 1.0 - initial release
// ============================================================================
module pl_symbol_scrambler #(
    parameter int W         = 8,
    parameter int HDR_LEN   = 90,
    parameter int FRAME_LEN = 16290,
    parameter int CW        = 15
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_sof,
    input  logic signed [W-1:0] i_i,
    input  logic signed [W-1:0] i_q,
    input  logic [1:0]          i_rn,
    output logic                o_rnd_en,
    output logic                o_rnd_restart,
    output logic                o_valid,
    input  logic                i_ready,
    output logic signed [W-1:0] o_i,
    output logic signed [W-1:0] o_q,
    output logic                o_sof,
    output logic                o_err
);

    localparam logic [CW-1:0]       C_HDR_LEN   = CW'(HDR_LEN);
    localparam logic [CW-1:0]       C_FRAME_LEN = CW'(FRAME_LEN);
    localparam logic signed [W-1:0] C_MIN       = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] C_MAX       = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } state_t;

    function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] x);
        return (x == C_MIN) ? C_MAX : -x;
    endfunction

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                rnd_en_q, rnd_en_d, restart_q, restart_d, err_q, err_d;
    logic                s1_vld_q, s1_vld_d, s1_pay_q, s1_pay_d, s1_sof_q, s1_sof_d;
    logic signed [W-1:0] s1_i_q, s1_i_d, s1_q_q, s1_q_d;
    logic                s2_vld_q, s2_pay_q, s2_sof_q;
    logic signed [W-1:0] s2_i_q, s2_q_q;
    logic signed [W-1:0] fifo_i_q [4];
    logic signed [W-1:0] fifo_i_d [4];
    logic signed [W-1:0] fifo_q_q [4];
    logic signed [W-1:0] fifo_q_d [4];
    logic                fifo_sof_q [4];
    logic                fifo_sof_d [4];
    logic [1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]          count_q, count_d;
    logic                accept, take, is_pay, push, pop;
    logic [1:0]          rot;
    logic signed [W-1:0] rot_i, rot_q;

    // Credit covers both in-flight stages, so the pipeline itself never stalls.
    assign o_ready = (4'(count_q) + 4'(s1_vld_q) + 4'(s2_vld_q)) < 4'd4;
    assign accept  = i_valid & o_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        take      = 1'b0;
        is_pay    = 1'b0;
        err_d     = 1'b0;
        restart_d = 1'b0;
        if (accept) begin
            if (i_sof) begin
                take      = 1'b1;
                restart_d = 1'b1;
                cnt_d     = CW'(1);
                err_d     = (state_q != ST_IDLE);
                state_d   = (HDR_LEN == 1) ? ST_PAY : ST_HDR;
            end else begin
                case (state_q)
                    ST_IDLE: err_d = 1'b1;
                    ST_HDR: begin
                        take  = 1'b1;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_d == C_HDR_LEN) state_d = ST_PAY;
                    end
                    ST_PAY: begin
                        take   = 1'b1;
                        is_pay = 1'b1;
                        cnt_d  = cnt_q + CW'(1);
                        if (cnt_d == C_FRAME_LEN) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
        rnd_en_d = take & is_pay;
        s1_vld_d = take;
        s1_pay_d = is_pay;
        s1_sof_d = i_sof;
        s1_i_d   = i_i;
        s1_q_d   = i_q;
    end

    // Stage 2 sees the randomizer value that followed this symbol's advance.
    always_comb begin
        rot = s2_pay_q ? i_rn : 2'd0;
        case (rot)
            2'd1:    begin rot_i = neg_sat(s2_q_q); rot_q = s2_i_q;          end
            2'd2:    begin rot_i = neg_sat(s2_i_q); rot_q = neg_sat(s2_q_q); end
            2'd3:    begin rot_i = s2_q_q;          rot_q = neg_sat(s2_i_q); end
            default: begin rot_i = s2_i_q;          rot_q = s2_q_q;          end
        endcase
    end

    always_comb begin
        push       = s2_vld_q;
        pop        = o_valid & i_ready;
        fifo_i_d   = fifo_i_q;
        fifo_q_d   = fifo_q_q;
        fifo_sof_d = fifo_sof_q;
        if (push) begin
            fifo_i_d[wr_ptr_q]   = rot_i;
            fifo_q_d[wr_ptr_q]   = rot_q;
            fifo_sof_d[wr_ptr_q] = s2_sof_q;
        end
        wr_ptr_d = wr_ptr_q + 2'(push);
        rd_ptr_d = rd_ptr_q + 2'(pop);
        count_d  = count_q + 3'(push) - 3'(pop);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rnd_en_q  <= 1'b0;
            restart_q <= 1'b0;
            err_q     <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_pay_q  <= 1'b0;
            s1_sof_q  <= 1'b0;
            s1_i_q    <= '0;
            s1_q_q    <= '0;
            s2_vld_q  <= 1'b0;
            s2_pay_q  <= 1'b0;
            s2_sof_q  <= 1'b0;
            s2_i_q    <= '0;
            s2_q_q    <= '0;
            for (int k = 0; k < 4; k++) begin
                fifo_i_q[k]   <= '0;
                fifo_q_q[k]   <= '0;
                fifo_sof_q[k] <= 1'b0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rnd_en_q   <= rnd_en_d;
            restart_q  <= restart_d;
            err_q      <= err_d;
            s1_vld_q   <= s1_vld_d;
            s1_pay_q   <= s1_pay_d;
            s1_sof_q   <= s1_sof_d;
            s1_i_q     <= s1_i_d;
            s1_q_q     <= s1_q_d;
            s2_vld_q   <= s1_vld_q;
            s2_pay_q   <= s1_pay_q;
            s2_sof_q   <= s1_sof_q;
            s2_i_q     <= s1_i_q;
            s2_q_q     <= s1_q_q;
            fifo_i_q   <= fifo_i_d;
            fifo_q_q   <= fifo_q_d;
            fifo_sof_q <= fifo_sof_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign o_rnd_en      = rnd_en_q;
    assign o_rnd_restart = restart_q;
    assign o_err         = err_q;
    assign o_valid       = (count_q != 3'd0);
    assign o_i           = fifo_i_q[rd_ptr_q];
    assign o_q           = fifo_q_q[rd_ptr_q];
    assign o_sof         = fifo_sof_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_pl_symbol_scrambler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pl_symbol_scrambler
// Description : Randomized self-checking bench with a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pl_symbol_scrambler;

    localparam int W         = 8;
    localparam int HDR_LEN   = 2;
    localparam int FRAME_LEN = 6;
    localparam int CW        = 4;

    logic              clk = 1'b0;
    logic              i_reset, i_valid, i_sof, i_ready;
    logic signed [7:0] i_i, i_q;
    logic [1:0]        i_rn;
    logic              o_ready, o_rnd_en, o_rnd_restart, o_valid, o_sof, o_err;
    logic signed [7:0] o_i, o_q;

    pl_symbol_scrambler #(.W(W), .HDR_LEN(HDR_LEN), .FRAME_LEN(FRAME_LEN), .CW(CW)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_sof(i_sof), .i_i(i_i), .i_q(i_q), .i_rn(i_rn),
        .o_rnd_en(o_rnd_en), .o_rnd_restart(o_rnd_restart), .o_valid(o_valid),
        .i_ready(i_ready), .o_i(o_i), .o_q(o_q), .o_sof(o_sof), .o_err(o_err)
    );

    always #5 clk = ~clk;

    // Randomizer stand-in: value k after k advances since the last restart.
    logic [1:0] rn_tab [256];
    logic [7:0] rn_idx;
    always @(posedge clk or posedge i_reset) begin
        if (i_reset)            rn_idx <= 8'd0;
        else if (o_rnd_restart) rn_idx <= 8'd0;
        else if (o_rnd_en)      rn_idx <= rn_idx + 8'd1;
    end
    assign i_rn = rn_tab[rn_idx];

    typedef struct {int i; int q; bit sof;} exp_t;
    exp_t exp_q[$];
    int   n_tests = 0, n_fail = 0;
    int   m_pos = 0, m_err = 0, m_rst = 0, m_pay = 0;
    int   n_en = 0, n_rst = 0, n_err = 0, n_pop = 0, n_sof_out = 0;
    int   last_i = 0, last_q = 0;
    bit   rdy_mode = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v);
        return (v > 127) ? 127 : ((v < -128) ? -128 : v);
    endfunction

    // Frame-level model: position within frame decides header/payload and Rn.
    task automatic model_accept(input int ii, input int qq, input bit s);
        exp_t e;
        int   r, t;
        if (s) begin
            if (m_pos != 0) m_err++;
            m_pos = 1;
            m_rst++;
            e.i = ii; e.q = qq; e.sof = 1'b1;
            exp_q.push_back(e);
        end else if (m_pos == 0) begin
            m_err++;
        end else begin
            m_pos++;
            r = 0;
            if (m_pos > HDR_LEN) begin
                r = int'(rn_tab[m_pos - HDR_LEN]);
                m_pay++;
            end
            e.i = ii; e.q = qq; e.sof = 1'b0;
            repeat (r) begin t = e.i; e.i = -e.q; e.q = t; end
            e.i = clamp(e.i);
            e.q = clamp(e.q);
            exp_q.push_back(e);
            if (m_pos == FRAME_LEN) m_pos = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!i_reset) begin
            if (o_valid && i_ready) begin
                n_pop++;
                last_i = int'(o_i);
                last_q = int'(o_q);
                if (o_sof) n_sof_out++;
                if (exp_q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    check("out_i", int'(o_i), exp_q[0].i);
                    check("out_q", int'(o_q), exp_q[0].q);
                    check("out_sof", int'(o_sof), int'(exp_q[0].sof));
                    void'(exp_q.pop_front());
                end
            end
            if (o_rnd_en)      n_en++;
            if (o_rnd_restart) n_rst++;
            if (o_err)         n_err++;
            if (i_valid && o_ready) model_accept(int'(i_i), int'(i_q), i_sof);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_mode) i_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input bit s, input int ii, input int qq);
        int g;
        i_valid = 1'b1; i_sof = s; i_i = 8'(ii); i_q = 8'(qq);
        g = 0;
        @(negedge clk);
        while (!o_ready && g < 100) begin tick(); @(negedge clk); g++; end
        if (g >= 100) check("send_timeout", 0, 1);
        tick();
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || o_valid) && g < 200) begin tick(); g++; end
        if (g >= 200) check("drain_timeout", 0, 1);
        repeat (3) tick();
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        exp_q.delete();
        m_pos = 0;
        tick(); tick();
        i_reset = 1'b0;
        tick();
    endtask

    int b_en, b_rst, b_err, b_pop, b_sof, lat, k, en_stall;
    int sti [6];
    int stq [6];
    int b_men, b_mrst, b_merr;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rn_tab[i] = 2'($urandom);
        i_reset = 1'b1; i_valid = 1'b0; i_sof = 1'b0; i_i = '0; i_q = '0; i_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        check("rst_o_ready", int'(o_ready), 1);
        check("rst_o_valid", int'(o_valid), 0);
        check("rst_rnd_en", int'(o_rnd_en), 0);
        check("rst_restart", int'(o_rnd_restart), 0);
        check("rst_err", int'(o_err), 0);
        check("rst_data", int'({o_i, o_q, o_sof}), 0);
        tick();
        i_reset = 1'b0;
        tick();

        // Directed frame: constant symbol, Rn 0,1,2,3 on the payload.
        rn_tab[1] = 2'd0; rn_tab[2] = 2'd1; rn_tab[3] = 2'd2; rn_tab[4] = 2'd3;
        b_en = n_en; b_rst = n_rst; b_sof = n_sof_out; b_pop = n_pop;
        send(1'b1, 10, 20);
        lat = 1;
        while (!o_valid && lat < 20) begin tick(); lat++; end
        check("latency", lat, 3);
        for (int s = 0; s < 5; s++) send(1'b0, 10, 20);
        drain();
        check("frame_pops", n_pop - b_pop, 6);
        check("frame_rnd_en", n_en - b_en, 4);
        check("frame_restart", n_rst - b_rst, 1);
        check("frame_sof_out", n_sof_out - b_sof, 1);
        check("frame_last_i", last_i, 20);
        check("frame_last_q", last_q, -10);

        // Saturating negation, then a sof arriving as the 4th symbol.
        rn_tab[1] = 2'd2;
        b_en = n_en; b_rst = n_rst; b_err = n_err;
        send(1'b1, 1, 1);
        send(1'b0, 1, 1);
        send(1'b0, -128, 5);
        drain();
        check("sat_i", last_i, 127);
        check("sat_q", last_q, -5);
        send(1'b1, 3, 4);
        send(1'b0, 7, 9);
        drain();
        check("midsof_err", n_err - b_err, 1);
        check("midsof_restart", n_rst - b_rst, 2);
        check("midsof_rnd_en", n_en - b_en, 1);
        check("midsof_hdr_i", last_i, 7);
        check("midsof_hdr_q", last_q, 9);

        // Symbol without sof straight after reset is dropped.
        do_reset();
        b_en = n_en; b_err = n_err; b_pop = n_pop;
        send(1'b0, 5, 5);
        repeat (6) tick();
        check("drop_err", n_err - b_err, 1);
        check("drop_rnd_en", n_en - b_en, 0);
        check("drop_pops", n_pop - b_pop, 0);

        // Backpressure: downstream stalled with continuous input.
        for (int s = 0; s < 6; s++) begin
            sti[s] = $urandom_range(0, 255) - 128;
            stq[s] = $urandom_range(0, 255) - 128;
        end
        b_pop = n_pop;
        i_ready = 1'b0;
        k = 0; en_stall = 0;
        for (int c = 0; c < 10; c++) begin
            i_valid = (k < 6);
            i_sof   = (k == 0);
            i_i     = 8'(sti[k]);
            i_q     = 8'(stq[k]);
            @(negedge clk);
            if (i_valid && o_ready) k++;
            if (c >= 5 && o_rnd_en) en_stall++;
            tick();
        end
        i_valid = 1'b0;
        check("stall_accepts", k, 4);
        check("stall_rnd_en", en_stall, 0);
        check("stall_o_ready", int'(o_ready), 0);
        i_ready = 1'b1;
        for (int s = 4; s < 6; s++) send(1'b0, sti[s], stq[s]);
        drain();
        check("stall_pops", n_pop - b_pop, 6);

        // Reset mid-payload with three symbols parked in the FIFO.
        i_ready = 1'b0;
        send(1'b1, 11, 12);
        send(1'b0, 13, 14);
        send(1'b0, 15, 16);
        repeat (3) tick();
        check("pre_rst_valid", int'(o_valid), 1);
        #1 i_reset = 1'b1;
        #1;
        check("midrst_valid", int'(o_valid), 0);
        check("midrst_ready", int'(o_ready), 1);
        exp_q.delete();
        m_pos = 0;
        tick();
        i_reset = 1'b0;
        i_ready = 1'b1;
        tick();
        b_pop = n_pop; b_err = n_err;
        send(1'b1, 21, -22);
        for (int s = 0; s < 5; s++) send(1'b0, 30 + s, -40 - s);
        drain();
        check("postrst_pops", n_pop - b_pop, 6);
        check("postrst_err", n_err - b_err, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 256; i++) rn_tab[i] = 2'($urandom);
        b_en = n_en; b_rst = n_rst; b_err = n_err;
        b_men = m_pay; b_mrst = m_rst; b_merr = m_err;
        rdy_mode = 1'b1;
        for (int s = 0; s < 400; s++) begin
            int g;
            bit sf;
            sf = (m_pos == 0) ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 29) == 0);
            send(sf, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
            g = $urandom_range(0, 2);
            repeat (g) tick();
        end
        rdy_mode = 1'b0;
        i_ready = 1'b1;
        drain();
        check("rand_rnd_en", n_en - b_en, m_pay - b_men);
        check("rand_restart", n_rst - b_rst, m_rst - b_mrst);
        check("rand_err", n_err - b_err, m_err - b_merr);
        check("rand_left", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
